// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring phase monitor.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCKED,
        FAULT
    } state_e;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_NOT_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_BAD_STEP   = 2'b10;

    // Widest ring the rotate helper supports; callers zero-extend into it.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v,
                                               input int unsigned      w);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot validity check and binary index encoder (combinational).
module onehot_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        is_onehot = $onehot(vec);
        idx       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Tracks a one-hot ring counter: phase index, lock acquisition, rotation count
// and sticky step/one-hot fault detection.
module ring_phase_monitor
    import ring_mon_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     in_valid,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_vld,
    output logic                     lock,
    output logic                     wrap_pulse,
    output logic [CNT_W-1:0]         rot_cnt,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int         IDX_W    = $clog2(WIDTH);
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;
    logic               phase_vld_q, phase_vld_d;
    logic               lock_q, lock_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   rot_cnt_q, rot_cnt_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               is_onehot;
    logic [IDX_W-1:0]   in_idx;
    logic [WIDTH-1:0]   expected;

    onehot_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec       (ring_in),
        .is_onehot (is_onehot),
        .idx       (in_idx)
    );

    assign expected = WIDTH'(rotl1(MAX_W'(prev_q), WIDTH));

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        phase_idx_d = phase_idx_q;
        phase_vld_d = phase_vld_q;
        wrap_d      = 1'b0;
        rot_cnt_d   = rot_cnt_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        if (err_clr) begin
            // Clear wins over sample evaluation; the concurrent sample seeds prev.
            state_d    = ACQUIRE;
            good_cnt_d = '0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            prev_d     = (in_valid && is_onehot) ? ring_in : '0;
            if (in_valid) begin
                phase_vld_d = is_onehot;
                if (is_onehot) phase_idx_d = in_idx;
            end
        end else if (in_valid && state_q != FAULT) begin
            phase_vld_d = is_onehot;
            if (is_onehot) phase_idx_d = in_idx;

            case (state_q)
                ACQUIRE: begin
                    if (!is_onehot) begin
                        good_cnt_d = '0;
                        prev_d     = '0;
                    end else if (prev_q == '0) begin
                        good_cnt_d = '0;
                        prev_d     = ring_in;
                    end else if (ring_in == expected) begin
                        prev_d     = ring_in;
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == LOCK_TGT) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                            rot_cnt_d  = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                        prev_d     = ring_in;
                    end
                end
                LOCKED: begin
                    if (!is_onehot) begin
                        state_d    = FAULT;
                        err_d      = 1'b1;
                        err_code_d = ERR_NOT_ONEHOT;
                    end else if (ring_in == expected) begin
                        prev_d = ring_in;
                        if (ring_in[0]) begin
                            wrap_d    = 1'b1;
                            rot_cnt_d = rot_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d    = FAULT;
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_STEP;
                    end
                end
                default: ;
            endcase
        end

        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ACQUIRE;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            phase_idx_q <= '0;
            phase_vld_q <= 1'b0;
            lock_q      <= 1'b0;
            wrap_q      <= 1'b0;
            rot_cnt_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            phase_idx_q <= phase_idx_d;
            phase_vld_q <= phase_vld_d;
            lock_q      <= lock_d;
            wrap_q      <= wrap_d;
            rot_cnt_q   <= rot_cnt_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign phase_idx  = phase_idx_q;
    assign phase_vld  = phase_vld_q;
    assign lock       = lock_q;
    assign wrap_pulse = wrap_q;
    assign rot_cnt    = rot_cnt_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Randomized + directed bench for ring_phase_monitor against a phase-index model.
module tb_ring_phase_monitor;

    localparam int W  = 4;
    localparam int LC = 3;
    localparam int CW = 8;
    localparam int IW = $clog2(W);

    localparam int M_ACQ    = 0;
    localparam int M_LOCKED = 1;
    localparam int M_FAULT  = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  ring_in;
    logic          in_valid;
    logic          err_clr;
    logic [IW-1:0] phase_idx;
    logic          phase_vld;
    logic          lock;
    logic          wrap_pulse;
    logic [CW-1:0] rot_cnt;
    logic          err;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    int pos;

    // Behavioural model: phase as integer index, -1 meaning "no reference yet".
    int m_mode, m_prev, m_good, m_idx, m_vld, m_wrap, m_rot, m_err, m_code;

    always #5 clk = ~clk;

    ring_phase_monitor #(
        .WIDTH    (W),
        .LOCK_CNT (LC),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ring_in    (ring_in),
        .in_valid   (in_valid),
        .err_clr    (err_clr),
        .phase_idx  (phase_idx),
        .phase_vld  (phase_vld),
        .lock       (lock),
        .wrap_pulse (wrap_pulse),
        .rot_cnt    (rot_cnt),
        .err        (err),
        .err_code   (err_code)
    );

    function automatic int idx_of(input logic [W-1:0] r);
        for (int i = 0; i < W; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_ACQ; m_prev = -1; m_good = 0; m_idx = 0; m_vld = 0;
        m_wrap = 0; m_rot = 0; m_err = 0; m_code = 0;
    endtask

    task automatic model_step(input logic [W-1:0] r, input logic v, input logic c);
        bit oh;
        int ix;
        oh = ($countones(r) == 1);
        ix = idx_of(r);
        m_wrap = 0;
        if (c) begin
            m_err = 0; m_code = 0; m_mode = M_ACQ; m_good = 0;
            m_prev = (v && oh) ? ix : -1;
            if (v) begin
                m_vld = oh;
                if (oh) m_idx = ix;
            end
            return;
        end
        if (!v || m_mode == M_FAULT) return;
        m_vld = oh;
        if (oh) m_idx = ix;
        if (m_mode == M_ACQ) begin
            if (!oh) begin
                m_good = 0; m_prev = -1;
            end else if (m_prev < 0) begin
                m_good = 0; m_prev = ix;
            end else if (ix == (m_prev + 1) % W) begin
                m_good++; m_prev = ix;
                if (m_good == LC) begin
                    m_mode = M_LOCKED; m_rot = 0;
                end
            end else begin
                m_good = 0; m_prev = ix;
            end
        end else begin
            if (!oh) begin
                m_mode = M_FAULT; m_err = 1; m_code = 1;
            end else if (ix == (m_prev + 1) % W) begin
                m_prev = ix;
                if (ix == 0) begin
                    m_wrap = 1; m_rot = (m_rot + 1) % (1 << CW);
                end
            end else begin
                m_mode = M_FAULT; m_err = 1; m_code = 2;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("phase_idx", int'(phase_idx), m_idx);
        check("phase_vld", int'(phase_vld), m_vld);
        check("lock", int'(lock), int'(m_mode == M_LOCKED));
        check("wrap_pulse", int'(wrap_pulse), m_wrap);
        check("rot_cnt", int'(rot_cnt), m_rot);
        check("err", int'(err), m_err);
        check("err_code", int'(err_code), m_code);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_idx"}, int'(phase_idx), 0);
        check({tag, "_vld"}, int'(phase_vld), 0);
        check({tag, "_lock"}, int'(lock), 0);
        check({tag, "_wrap"}, int'(wrap_pulse), 0);
        check({tag, "_rot"}, int'(rot_cnt), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_code"}, int'(err_code), 0);
    endtask

    always @(negedge rstn) model_reset();

    always @(posedge clk) begin
        if (rstn === 1'b1) model_step(ring_in, in_valid, err_clr);
        #1;
        if (cmp_en) compare_all();
    end

    task automatic step(input logic [W-1:0] r, input logic v, input logic c);
        @(negedge clk);
        ring_in  = r;
        in_valid = v;
        err_clr  = c;
        @(posedge clk);
        #2;
    endtask

    task automatic adv();
        logic [W-1:0] one;
        one = 1;
        pos = (pos + 1) % W;
        step(one << pos, 1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rv;
        logic [W-1:0] one;
        int r;
        one = 1;
        rstn = 1'b0; ring_in = '0; in_valid = 1'b0; err_clr = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        cmp_en = 1'b1;
        @(negedge clk) rstn = 1'b1;

        // Acquire from reset
        pos = W - 1;
        for (int k = 0; k < 4; k++) begin
            adv();
            check("t1_idx", int'(phase_idx), k);
            check("t1_lock", int'(lock), (k == 3) ? 1 : 0);
            check("t1_err", int'(err), 0);
        end

        // Rotation counting
        adv();
        check("t2_wrap", int'(wrap_pulse), 1);
        check("t2_rot1", int'(rot_cnt), 1);
        adv();
        check("t2_wrap_low", int'(wrap_pulse), 0);
        repeat (8) adv();
        check("t2_rot3", int'(rot_cnt), 3);

        // Non-one-hot fault, sticky through good samples
        step(4'b0110, 1'b1, 1'b0);
        check("t3_err", int'(err), 1);
        check("t3_code", int'(err_code), 1);
        check("t3_lock", int'(lock), 0);
        check("t3_vld", int'(phase_vld), 0);
        check("t3_idx", int'(phase_idx), 1);
        adv(); adv();
        check("t3_err_hold", int'(err), 1);
        check("t3_idx_hold", int'(phase_idx), 1);

        // Clear, relock, bad step, clear, relock
        pos = 0;
        step(4'b0001, 1'b1, 1'b1);
        check("t4_clr_err", int'(err), 0);
        check("t4_clr_code", int'(err_code), 0);
        adv(); adv();
        check("t4_prelock", int'(lock), 0);
        adv();
        check("t4_lock", int'(lock), 1);
        adv(); adv();
        step(4'b1000, 1'b1, 1'b0);
        check("t4_code", int'(err_code), 2);
        check("t4_lock_drop", int'(lock), 0);
        pos = 0;
        step(4'b0001, 1'b1, 1'b1);
        check("t4_clr2", int'(err), 0);
        adv(); adv();
        check("t4_prelock2", int'(lock), 0);
        adv();
        check("t4_relock", int'(lock), 1);

        // Stall keeps everything
        repeat (5) begin
            step(4'b1000, 1'b0, 1'b0);
            check("t5_lock", int'(lock), 1);
            check("t5_idx", int'(phase_idx), 3);
            check("t5_err", int'(err), 0);
        end
        adv();
        check("t5_resume_lock", int'(lock), 1);
        check("t5_resume_rot", int'(rot_cnt), 1);

        // Async reset mid-cycle, then counter wrap
        repeat (16) adv();
        check("t6_rot5", int'(rot_cnt), 5);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 check_all_zero("t6_async");
        @(negedge clk) rstn = 1'b1;
        pos = W - 1;
        repeat (4) adv();
        check("t6_lock", int'(lock), 1);
        repeat (255 * 4) adv();
        check("t6_rot255", int'(rot_cnt), 255);
        adv();
        check("t6_rot_wrap", int'(rot_cnt), 0);
        check("t6_wrap", int'(wrap_pulse), 1);
        check("t6_no_err", int'(err), 0);

        // Randomized traffic against the model
        repeat (3000) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                step(ring_in, 1'b0, 1'b0);
            end else if (r < 9) begin
                rv = W'($urandom_range(0, (1 << W) - 1));
                step(rv, 1'b1, 1'b0);
            end else if (r < 12) begin
                pos = (pos + 1) % W;
                step(one << pos, 1'b1, 1'b1);
            end else if (r < 14) begin
                pos = (pos + 2) % W;
                step(one << pos, 1'b1, 1'b0);
            end else if (r < 16) begin
                step(one << pos, 1'b1, 1'b0);
            end else if (r < 17) begin
                @(posedge clk);
                #3 rstn = 1'b0;
                #1 check_all_zero("rand_async");
                @(negedge clk) rstn = 1'b1;
            end else begin
                adv();
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
